// File: rtl/ethpipe_pkg.sv
// ethpipe RX slotter shared definitions: FSM states, status bits,
// slot header word offsets, CRC residue and minimum frame length.
package ethpipe_pkg;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_DROP,
    ST_HDR1,
    ST_HDR2,
    ST_HDR3
  } rx_state_e;

  localparam int STS_VALID = 31;
  localparam int STS_FCS   = 30;
  localparam int STS_RXER  = 29;
  localparam int STS_TRUNC = 28;

  localparam int HDR_STATUS = 0;
  localparam int HDR_TS_LO  = 1;
  localparam int HDR_TS_HI  = 2;
  localparam int HDR_RSVD   = 3;
  localparam int HDR_DATA   = 4;

  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
  localparam int          MIN_FRAME   = 64;

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

endpackage

// File: rtl/ethpipe_crc32_d8.sv
// Byte-wide Ethernet CRC-32 (MSB-first register, bits fed LSB-first).
// Ports: gmii_rx_clk, sys_rst_n, init, en, d[7:0] -> crc[31:0].
module ethpipe_crc32_d8 (
  input  logic        gmii_rx_clk,
  input  logic        sys_rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  logic [31:0] nxt;

  always_comb begin
    nxt = crc;
    for (int i = 0; i < 8; i++) begin
      if (nxt[31] ^ d[i])
        nxt = {nxt[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else
        nxt = {nxt[30:0], 1'b0};
    end
  end

  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      crc <= '1;
    else if (init)
      crc <= '1;
    else if (en)
      crc <= nxt;
  end

endmodule

// File: rtl/ethpipe_rx_slotter.sv
// Multi-slot GMII receiver: preamble/SFD detect, timestamp, ring of RX
// slots with occupancy/release, drop counter. Ports: gmii_rx_clk,
// sys_rst_n, global_counter, gmii_rxd/dv/er in; slot_rx_eth_* RAM write
// port, slot_release in, slot_full, slot_rx_complete(_idx), drop_count.
// Optional FCS check: define ETHPIPE_RX_FCS_CHECK_EN.
module ethpipe_rx_slotter
  import ethpipe_pkg::*;
#(
  parameter int SLOT_NUM  = 4,
  parameter int SLOT_AW   = 9,
  parameter int MAX_FRAME = 1518
) (
  input  logic                                gmii_rx_clk,
  input  logic                                sys_rst_n,
  input  logic [63:0]                         global_counter,
  input  logic [7:0]                          gmii_rxd,
  input  logic                                gmii_rx_dv,
  input  logic                                gmii_rx_er,
  output logic                                slot_rx_eth_wr_en,
  output logic [$clog2(SLOT_NUM)+SLOT_AW-1:0] slot_rx_eth_address,
  output logic [31:0]                         slot_rx_eth_data,
  output logic [3:0]                          slot_rx_eth_byte_en,
  input  logic [SLOT_NUM-1:0]                 slot_release,
  output logic [SLOT_NUM-1:0]                 slot_full,
  output logic                                slot_rx_complete,
  output logic [$clog2(SLOT_NUM)-1:0]         slot_rx_complete_idx,
  output logic [31:0]                         drop_count
);

  localparam int SW = $clog2(SLOT_NUM);
  localparam int AW = SW + SLOT_AW;

  rx_state_e state, state_n;

  logic [SW-1:0]      wr_ptr;
  logic [15:0]        byte_cnt;
  logic [63:0]        ts;
  logic               trunc;
  logic               rxer;
  logic               fcs_err;

  logic               wr_d;
  logic [SLOT_AW-1:0] word;
  logic [31:0]        data_d;
  logic [3:0]         be_d;
  logic               commit;
  logic               drop_inc;
  logic               sfd_hit;
  logic               cnt_inc;
  logic               trunc_set;
  logic               rxer_set;
  logic [31:0]        status;
  logic [SLOT_NUM-1:0] commit_mask;

`ifdef ETHPIPE_RX_FCS_CHECK_EN
  logic        crc_en;
  logic [31:0] crc;

  assign crc_en = (state == ST_DATA) & gmii_rx_dv;

  ethpipe_crc32_d8 u_crc (
    .gmii_rx_clk (gmii_rx_clk),
    .sys_rst_n   (sys_rst_n),
    .init        (sfd_hit),
    .en          (crc_en),
    .d           (gmii_rxd),
    .crc         (crc)
  );

  // Truncated frames lost their FCS, so they always report an error.
  assign fcs_err = (crc != CRC_RESIDUE) | trunc;
`else
  assign fcs_err = 1'b0;
`endif

  always_comb begin
    status            = '0;
    status[STS_VALID] = 1'b1;
    status[STS_FCS]   = fcs_err;
    status[STS_RXER]  = rxer;
    status[STS_TRUNC] = trunc;
    status[15:0]      = byte_cnt;
  end

  assign commit_mask = commit ? (SLOT_NUM'(1) << wr_ptr) : '0;

  always_comb begin
    state_n   = state;
    wr_d      = 1'b0;
    word      = '0;
    data_d    = '0;
    be_d      = '0;
    commit    = 1'b0;
    drop_inc  = 1'b0;
    sfd_hit   = 1'b0;
    cnt_inc   = 1'b0;
    trunc_set = 1'b0;
    rxer_set  = 1'b0;
    unique case (state)
      ST_ARM: begin
        if (!gmii_rx_dv) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (gmii_rx_dv) begin
          if (slot_full[wr_ptr]) begin
            state_n  = ST_DROP;
            drop_inc = 1'b1;
          end else begin
            state_n = ST_PRE;
          end
        end
      end
      ST_PRE: begin
        if (!gmii_rx_dv) begin
          state_n = ST_IDLE;
        end else if (gmii_rxd == SFD_BYTE) begin
          state_n = ST_DATA;
          sfd_hit = 1'b1;
        end else if (gmii_rxd != PRE_BYTE) begin
          state_n = ST_DROP;
        end
      end
      ST_DATA: begin
        if (gmii_rx_dv) begin
          rxer_set = gmii_rx_er;
          if (byte_cnt == 16'(MAX_FRAME)) begin
            trunc_set = 1'b1;
          end else begin
            cnt_inc = 1'b1;
            wr_d    = 1'b1;
            word    = SLOT_AW'(HDR_DATA) + byte_cnt[SLOT_AW+1:2];
            be_d    = 4'b0001 << byte_cnt[1:0];
            data_d  = {24'd0, gmii_rxd} << {byte_cnt[1:0], 3'b000};
          end
        end else if (byte_cnt < 16'(MIN_FRAME)) begin
          state_n  = ST_IDLE;
          drop_inc = 1'b1;
        end else begin
          state_n = ST_HDR1;
          wr_d    = 1'b1;
          word    = SLOT_AW'(HDR_TS_LO);
          be_d    = 4'b1111;
          data_d  = ts[31:0];
        end
      end
      ST_HDR1: begin
        state_n = ST_HDR2;
        wr_d    = 1'b1;
        word    = SLOT_AW'(HDR_TS_HI);
        be_d    = 4'b1111;
        data_d  = ts[63:32];
      end
      ST_HDR2: begin
        state_n = ST_HDR3;
        wr_d    = 1'b1;
        word    = SLOT_AW'(HDR_STATUS);
        be_d    = 4'b1111;
        data_d  = status;
      end
      ST_HDR3: begin
        state_n = ST_IDLE;
        commit  = 1'b1;
      end
      ST_DROP: begin
        if (!gmii_rx_dv) state_n = ST_IDLE;
      end
      default: state_n = ST_ARM;
    endcase
  end

  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state                <= ST_ARM;
      wr_ptr               <= '0;
      byte_cnt             <= '0;
      ts                   <= '0;
      trunc                <= 1'b0;
      rxer                 <= 1'b0;
      slot_rx_eth_wr_en    <= 1'b0;
      slot_rx_eth_address  <= '0;
      slot_rx_eth_data     <= '0;
      slot_rx_eth_byte_en  <= '0;
      slot_full            <= '0;
      slot_rx_complete     <= 1'b0;
      slot_rx_complete_idx <= '0;
      drop_count           <= '0;
    end else begin
      state               <= state_n;
      slot_rx_eth_wr_en   <= wr_d;
      slot_rx_eth_address <= wr_d ? AW'({wr_ptr, word}) : '0;
      slot_rx_eth_data    <= data_d;
      slot_rx_eth_byte_en <= be_d;
      slot_rx_complete    <= commit;
      slot_full <= (slot_full & ~slot_release) | commit_mask;
      if (commit) begin
        slot_rx_complete_idx <= wr_ptr;
        wr_ptr               <= wr_ptr + SW'(1);
      end
      if (drop_inc && (drop_count != '1))
        drop_count <= drop_count + 32'd1;
      if (sfd_hit) begin
        byte_cnt <= '0;
        trunc    <= 1'b0;
        rxer     <= 1'b0;
        ts       <= global_counter;
      end else begin
        if (cnt_inc)   byte_cnt <= byte_cnt + 16'd1;
        if (trunc_set) trunc    <= 1'b1;
        if (rxer_set)  rxer     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ethpipe_rx_slotter.sv
// Self-checking bench for ethpipe_rx_slotter: frame-level model predicts
// every RAM write/commit per cycle; literal checks pin key values.
module tb_ethpipe_rx_slotter;

  localparam int SLOT_NUM  = 4;
  localparam int SLOT_AW   = 9;
  localparam int MAX_FRAME = 1518;
  localparam int AW        = 11;

  logic          gmii_rx_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [63:0]   global_counter = '0;
  logic [7:0]    gmii_rxd = '0;
  logic          gmii_rx_dv = 1'b0;
  logic          gmii_rx_er = 1'b0;
  logic          wr_en;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic [3:0]    slot_release = '0;
  logic [3:0]    slot_full;
  logic          cmpl;
  logic [1:0]    cidx;
  logic [31:0]   drop_count;

  ethpipe_rx_slotter #(
    .SLOT_NUM (SLOT_NUM),
    .SLOT_AW  (SLOT_AW),
    .MAX_FRAME(MAX_FRAME)
  ) dut (
    .gmii_rx_clk         (gmii_rx_clk),
    .sys_rst_n           (sys_rst_n),
    .global_counter      (global_counter),
    .gmii_rxd            (gmii_rxd),
    .gmii_rx_dv          (gmii_rx_dv),
    .gmii_rx_er          (gmii_rx_er),
    .slot_rx_eth_wr_en   (wr_en),
    .slot_rx_eth_address (addr),
    .slot_rx_eth_data    (wdata),
    .slot_rx_eth_byte_en (be),
    .slot_release        (slot_release),
    .slot_full           (slot_full),
    .slot_rx_complete    (cmpl),
    .slot_rx_complete_idx(cidx),
    .drop_count          (drop_count)
  );

  always #5 gmii_rx_clk = ~gmii_rx_clk;

  int cyc = 0;
  always @(posedge gmii_rx_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    be;
  } wr_t;

  typedef struct {
    int         c;
    logic [1:0] idx;
  } cp_t;

  wr_t  exp_wr[$];
  cp_t  exp_cp[$];
  logic [31:0] shadow [0:2**AW-1];
  logic [7:0]  fq[$];
  logic [3:0]  m_full = '0;
  logic [1:0]  m_ptr = '0;
  logic [31:0] m_drop = '0;
  logic [1:0]  last_idx = '0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cyc %0d)", nm, cyc);
  endtask

  always @(negedge gmii_rx_clk) begin
    logic [31:0] mask;
    wr_t e;
    cp_t p;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (wr_en) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) shadow[addr][8*i +: 8] = wdata[8*i +: 8];
      if (exp_wr.size() > 0 && exp_wr[0].c == cyc) begin
        e = exp_wr.pop_front();
        check("wr_addr", 64'(addr), 64'(e.a));
        check("wr_be", 64'(be), 64'(e.be));
        check("wr_data", 64'(wdata & mask), 64'(e.d));
      end else begin
        fail_now("wr_unexpected");
      end
    end else if (exp_wr.size() > 0 && exp_wr[0].c == cyc) begin
      void'(exp_wr.pop_front());
      fail_now("wr_absent");
    end
    if (cmpl) begin
      last_idx = cidx;
      if (exp_cp.size() > 0 && exp_cp[0].c == cyc) begin
        p = exp_cp.pop_front();
        check("complete_idx", 64'(cidx), 64'(p.idx));
      end else begin
        fail_now("complete_unexpected");
      end
    end else if (exp_cp.size() > 0 && exp_cp[0].c == cyc) begin
      void'(exp_cp.pop_front());
      fail_now("complete_absent");
    end
  end

  task automatic step();
    @(posedge gmii_rx_clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  function automatic logic [31:0] eth_crc(int n);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < n; i++) begin
      c ^= 32'(fq[i]);
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit fcs_bad(int len);
    logic [31:0] c;
    if (len < 4) return 1'b1;
    c = eth_crc(len - 4);
    return {fq[len-1], fq[len-2], fq[len-3], fq[len-4]} != c;
  endfunction

  task automatic build_seq(int n);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(8'(i));
  endtask

  task automatic build_good(int payload);
    logic [31:0] f;
    fq.delete();
    for (int i = 0; i < payload; i++) fq.push_back(8'($urandom));
    f = eth_crc(payload);
    for (int i = 0; i < 4; i++) fq.push_back(f[8*i +: 8]);
  endtask

  task automatic rel(logic [3:0] m);
    slot_release = m;
    m_full &= ~m;
    step();
    slot_release = '0;
  endtask

  task automatic chk_rst_out(string nm);
    check({nm, "_wr_en"}, 64'(wr_en), 64'(0));
    check({nm, "_addr"}, 64'(addr), 64'(0));
    check({nm, "_data"}, 64'(wdata), 64'(0));
    check({nm, "_be"}, 64'(be), 64'(0));
    check({nm, "_full"}, 64'(slot_full), 64'(0));
    check({nm, "_cmpl"}, 64'(cmpl), 64'(0));
    check({nm, "_idx"}, 64'(cidx), 64'(0));
    check({nm, "_drop"}, 64'(drop_count), 64'(0));
  endtask

  task automatic chk_state(string nm);
    check({nm, "_slot_full"}, 64'(slot_full), 64'(m_full));
    check({nm, "_drop_count"}, 64'(drop_count), 64'(m_drop));
  endtask

  // Drives one frame from fq; predicts the slot writes from frame rules.
  // cut >= 0 asserts reset just before data byte 'cut'.
  task automatic send(int npre, logic [7:0] sfd, int er_at,
                      logic [63:0] ts, int cut);
    int len;
    int stored;
    bit trunc;
    bit er;
    bit take;
    logic [1:0] slot;
    logic [31:0] st;
    wr_t e;
    cp_t p;
    len    = fq.size();
    stored = (len > MAX_FRAME) ? MAX_FRAME : len;
    trunc  = len > MAX_FRAME;
    er     = er_at >= 0 && er_at < len;
    slot   = m_ptr;
    take   = 1'b0;
    if (m_full[m_ptr]) begin
      if (m_drop != '1) m_drop++;
    end else if (sfd == 8'hD5) begin
      take = 1'b1;
    end
    global_counter = ts;
    for (int i = 0; i < npre; i++) begin
      gmii_rx_dv = 1'b1;
      gmii_rxd   = 8'h55;
      step();
    end
    gmii_rxd = sfd;
    step();
    for (int n = 0; n < len; n++) begin
      if (cut >= 0 && n == cut) begin
        #2 sys_rst_n = 1'b0;
        #1 chk_rst_out("midrst");
        m_full = '0;
        m_ptr  = '0;
        m_drop = '0;
        take   = 1'b0;
        step();
        sys_rst_n = 1'b1;
      end
      gmii_rxd   = fq[n];
      gmii_rx_er = (n == er_at);
      if (take && n < MAX_FRAME && !(cut >= 0 && n == cut - 1)) begin
        e.c  = cyc + 1;
        e.a  = {slot, 9'(4 + n / 4)};
        e.d  = 32'(fq[n]) << (8 * (n % 4));
        e.be = 4'(1 << (n % 4));
        exp_wr.push_back(e);
      end
      step();
    end
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    gmii_rxd   = '0;
    if (take) begin
      if (stored < 64) begin
        if (m_drop != '1) m_drop++;
      end else begin
        st = 32'h8000_0000 | 32'(stored);
        if (trunc) st[28] = 1'b1;
        if (er) st[29] = 1'b1;
`ifdef ETHPIPE_RX_FCS_CHECK_EN
        if (trunc || fcs_bad(len)) st[30] = 1'b1;
`endif
        e.be = 4'hF;
        e.c = cyc + 1; e.a = {slot, 9'd1}; e.d = ts[31:0];
        exp_wr.push_back(e);
        e.c = cyc + 2; e.a = {slot, 9'd2}; e.d = ts[63:32];
        exp_wr.push_back(e);
        e.c = cyc + 3; e.a = {slot, 9'd0}; e.d = st;
        exp_wr.push_back(e);
        p.c = cyc + 4; p.idx = slot;
        exp_cp.push_back(p);
        m_full[slot] = 1'b1;
        m_ptr = m_ptr + 2'd1;
      end
    end
  endtask

  logic [31:0] w0;

  initial begin
    repeat (3) step();
    chk_rst_out("reset");
    sys_rst_n = 1'b1;
    idle(3);

    // 64-byte counting frame into slot 0, pinned by literals
    build_seq(64);
    send(7, 8'hD5, -1, 64'h1234, -1);
    repeat (4) @(negedge gmii_rx_clk);
    check("t1_word0_wr", 64'(wr_en), 64'(1));
    check("t1_word0_addr", 64'(addr), 64'(0));
`ifdef ETHPIPE_RX_FCS_CHECK_EN
    check("t1_word0", 64'(wdata), 64'h C000_0040);
`else
    check("t1_word0", 64'(wdata), 64'h8000_0040);
`endif
    @(negedge gmii_rx_clk);
    check("t1_complete", 64'(cmpl), 64'(1));
    check("t1_idx", 64'(cidx), 64'(0));
    check("t1_full", 64'(slot_full), 64'(1));
    idle(12);
    check("t1_word4", 64'(shadow[11'd4]), 64'h0302_0100);
    check("t1_word1", 64'(shadow[11'd1]), 64'h1234);
    check("t1_word2", 64'(shadow[11'd2]), 64'h0);
    chk_state("t1");

    // fill slots 1..3, then a fifth frame is dropped
    for (int k = 0; k < 3; k++) begin
      build_good(60 + 10 * k);
      send(7, 8'hD5, -1, {32'hA5A5_0000 + 32'(k), 32'h100 * 32'(k)}, -1);
      idle(12);
    end
    chk_state("fill");
    check("fill_full", 64'(slot_full), 64'hF);
    build_good(60);
    send(7, 8'hD5, -1, 64'h55, -1);
    idle(12);
    check("drop_full", 64'(drop_count), 64'(1));
    chk_state("drop");
    rel(4'b0001);
    rel(4'b0001);
    chk_state("rel0");
    build_good(70);
    send(7, 8'hD5, -1, 64'hDEAD_BEEF_0000_0006, -1);
    idle(12);
    check("sixth_idx", 64'(last_idx), 64'(0));
    chk_state("sixth");

    // truncated giant frame lands in slot 1
    rel(4'hF);
    build_seq(2000);
    send(7, 8'hD5, -1, 64'h77, -1);
    idle(12);
    w0 = shadow[{2'd1, 9'd0}];
`ifdef ETHPIPE_RX_FCS_CHECK_EN
    check("giant_word0", 64'(w0), 64'hD000_05EE);
`else
    check("giant_word0", 64'(w0), 64'h9000_05EE);
`endif
    chk_state("giant");

    // runt: counted, slot not consumed
    build_seq(40);
    send(7, 8'hD5, -1, 64'h88, -1);
    idle(12);
    check("runt_drop", 64'(drop_count), 64'(2));
    check("runt_full", 64'(slot_full), 64'b0010);

    // bad preamble (no count), then rx_er frame into slot 2
    build_good(60);
    send(3, 8'hAA, -1, 64'h99, -1);
    idle(12);
    chk_state("badpre");
    build_good(60);
    send(7, 8'hD5, 10, 64'h1_0000_0000, -1);
    idle(12);
    w0 = shadow[{2'd2, 9'd0}];
    check("rxer_bit29", 64'(w0[29]), 64'(1));
    check("rxer_bit30", 64'(w0[30]), 64'(0));

    // good FCS into slot 3, corrupted frame into slot 0
    build_good(80);
    send(7, 8'hD5, -1, 64'h2_0000_0003, -1);
    idle(12);
    w0 = shadow[{2'd3, 9'd0}];
    check("fcs_good_bit30", 64'(w0[30]), 64'(0));
    build_good(80);
    fq[5] = fq[5] ^ 8'h10;
    send(7, 8'hD5, -1, 64'h3, -1);
    idle(12);
    w0 = shadow[{2'd0, 9'd0}];
`ifdef ETHPIPE_RX_FCS_CHECK_EN
    check("fcs_bad_bit30", 64'(w0[30]), 64'(1));
`else
    check("fcs_bad_bit30", 64'(w0[30]), 64'(0));
`endif
    chk_state("fcs");

    // reset in the middle of a frame, then recover into slot 0
    build_good(100);
    send(7, 8'hD5, -1, 64'h4, 30);
    idle(12);
    chk_state("postrst");
    build_good(64);
    send(7, 8'hD5, -1, 64'h5, -1);
    idle(12);
    check("postrst_idx", 64'(last_idx), 64'(0));
    chk_state("final");

    check("wr_queue_empty", 64'(exp_wr.size()), 64'(0));
    check("cp_queue_empty", 64'(exp_cp.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
